// File: rtl/id_hazard_ctrl_pkg.sv
// Shared encodings and sizing helpers for the decode-stage hazard controller.
package id_hazard_ctrl_pkg;
   typedef enum logic {IDLE = 1'b0, DIV_BUSY = 1'b1} hilo_state_t;

   localparam logic STOP        = 1'b1;
   localparam logic NOSTOP      = 1'b0;
   localparam logic READ_ENABLE = 1'b1;

   // Select width: 0 = regfile plus one code per producer stage.
   function automatic int sel_width(input int num_fwd);
      return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
   endfunction
endpackage

// File: rtl/id_hazard_ctrl_fwd_pri.sv
// Per-operand priority encoder over producer stages; youngest matching stage wins.
module fwd_match_pri
   import id_hazard_ctrl_pkg::*;
#(
   parameter int NUM_FWD  = 2,
   parameter int LOAD_RDY = 2,
   parameter int SEL_W    = 2
) (
   input  logic                 rreg,
   input  logic [4:0]           ra,
   input  logic [NUM_FWD-1:0]   fwd_wreg,
   input  logic [5*NUM_FWD-1:0] fwd_wa,
   input  logic [NUM_FWD-1:0]   fwd_mreg,
   output logic [SEL_W-1:0]     sel,
   output logic                 load_use
);
   logic found;

   // Only the youngest match decides load-use; an older load behind a younger ALU write is shadowed.
   always_comb begin
      sel      = '0;
      load_use = 1'b0;
      found    = 1'b0;
      for (int k = 0; k < NUM_FWD; k++) begin
         if (!found && rreg == READ_ENABLE && fwd_wreg[k] &&
             fwd_wa[5*k +: 5] == ra && ra != 5'd0) begin
            found    = 1'b1;
            sel      = SEL_W'(k + 1);
            load_use = fwd_mreg[k] && (k < LOAD_RDY);
         end
      end
   end
endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard/forwarding controller: per-operand forward selects, load-use and
// HILO-busy stall request, multi-cycle div tracker and saturating stall counter.
module id_hazard_ctrl
   import id_hazard_ctrl_pkg::*;
#(
   parameter int NUM_FWD    = 2,
   parameter int LOAD_RDY   = 2,
   parameter int DIV_CYCLES = 34,
   parameter int CNT_W      = 32,
   localparam int SEL_W     = sel_width(NUM_FWD)
) (
   input  logic                 cpu_clk_50M,
   input  logic                 cpu_rst,
   input  logic                 id_valid,
   input  logic                 flush,
   input  logic                 rreg1,
   input  logic                 rreg2,
   input  logic [4:0]           ra1,
   input  logic [4:0]           ra2,
   input  logic                 id_div,
   input  logic                 id_hilo_use,
   input  logic [NUM_FWD-1:0]   fwd_wreg,
   input  logic [5*NUM_FWD-1:0] fwd_wa,
   input  logic [NUM_FWD-1:0]   fwd_mreg,
   output logic [SEL_W-1:0]     fwd1_sel,
   output logic [SEL_W-1:0]     fwd2_sel,
   output logic                 stallreq_id,
   output logic                 id_issue,
   output logic                 hilo_busy,
   output logic [CNT_W-1:0]     stall_cnt
);
   localparam int DW = $clog2(DIV_CYCLES + 1);

   hilo_state_t   state;
   logic [DW-1:0] dcnt;
   logic          lu1, lu2, hilo_stall;

   fwd_match_pri #(.NUM_FWD(NUM_FWD), .LOAD_RDY(LOAD_RDY), .SEL_W(SEL_W)) u_pri1 (
      .rreg(rreg1), .ra(ra1), .fwd_wreg(fwd_wreg), .fwd_wa(fwd_wa),
      .fwd_mreg(fwd_mreg), .sel(fwd1_sel), .load_use(lu1));

   fwd_match_pri #(.NUM_FWD(NUM_FWD), .LOAD_RDY(LOAD_RDY), .SEL_W(SEL_W)) u_pri2 (
      .rreg(rreg2), .ra(ra2), .fwd_wreg(fwd_wreg), .fwd_wa(fwd_wa),
      .fwd_mreg(fwd_mreg), .sel(fwd2_sel), .load_use(lu2));

   assign hilo_busy   = (state == DIV_BUSY);
   assign hilo_stall  = id_hilo_use & hilo_busy;
   assign stallreq_id = (id_valid & ~flush & (lu1 | lu2 | hilo_stall)) ? STOP : NOSTOP;
   assign id_issue    = id_valid & ~stallreq_id & ~flush;

   // A flush only blocks this cycle's issue; a div already counting down keeps HILO busy.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state     <= IDLE;
         dcnt      <= '0;
         stall_cnt <= '0;
      end else begin
         if (stallreq_id && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         case (state)
            IDLE: begin
               if (id_issue && id_div) begin
                  dcnt  <= DW'(DIV_CYCLES);
                  state <= DIV_BUSY;
               end
            end
            DIV_BUSY: begin
               dcnt <= dcnt - DW'(1);
               if (dcnt == DW'(1))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Randomized + directed bench for id_hazard_ctrl against a cycle-level behavioural model.
module tb_id_hazard_ctrl;
   localparam int NF   = 3;
   localparam int LR   = 2;
   localparam int DC   = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          cpu_rst, id_valid, flush, rreg1, rreg2, id_div, id_hilo_use;
   logic [4:0]    ra1, ra2;
   logic [NF-1:0] fwd_wreg, fwd_mreg;
   logic [5*NF-1:0] fwd_wa;
   logic [1:0]    fwd1_sel, fwd2_sel;
   logic          stallreq_id, id_issue, hilo_busy;
   logic [CW-1:0] stall_cnt;

   int n_cmp = 0, n_bad = 0;
   int busy_left = 0, mcnt = 0;
   bit chk_en = 0;

   id_hazard_ctrl #(.NUM_FWD(NF), .LOAD_RDY(LR), .DIV_CYCLES(DC), .CNT_W(CW)) dut (
      .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .id_valid(id_valid), .flush(flush),
      .rreg1(rreg1), .rreg2(rreg2), .ra1(ra1), .ra2(ra2), .id_div(id_div),
      .id_hilo_use(id_hilo_use), .fwd_wreg(fwd_wreg), .fwd_wa(fwd_wa), .fwd_mreg(fwd_mreg),
      .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stallreq_id(stallreq_id),
      .id_issue(id_issue), .hilo_busy(hilo_busy), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   // Source = first (youngest) stage writing the register being read; $zero is never sourced.
   function automatic int m_sel(input logic rr, input logic [4:0] ra);
      if (!rr || ra == 5'd0) return 0;
      for (int k = 0; k < NF; k++)
         if (fwd_wreg[k] && fwd_wa[5*k +: 5] == ra) return k + 1;
      return 0;
   endfunction

   function automatic bit m_lu(input int s);
      return s != 0 && fwd_mreg[s-1] && (s - 1) < LR;
   endfunction

   function automatic bit m_stall();
      return id_valid && !flush &&
             (m_lu(m_sel(rreg1, ra1)) || m_lu(m_sel(rreg2, ra2)) ||
              (id_hilo_use && busy_left > 0));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state advance at each clock edge.
   always @(posedge clk) begin
      if (cpu_rst) begin
         busy_left = 0;
         mcnt = 0;
      end else begin
         bit st;
         st = m_stall();
         if (st && mcnt < CMAX) mcnt++;
         if (busy_left > 0) busy_left--;
         else if (id_valid && !flush && !st && id_div) busy_left = DC;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit st;
         st = m_stall();
         chk("fwd1_sel", fwd1_sel, m_sel(rreg1, ra1));
         chk("fwd2_sel", fwd2_sel, m_sel(rreg2, ra2));
         chk("stallreq_id", stallreq_id, st);
         chk("id_issue", id_issue, id_valid && !flush && !st);
         chk("hilo_busy", hilo_busy, busy_left > 0);
         chk("stall_cnt", stall_cnt, mcnt);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      id_valid = 1; flush = 0; rreg1 = 0; rreg2 = 0; ra1 = 0; ra2 = 0;
      id_div = 0; id_hilo_use = 0; fwd_wreg = '0; fwd_wa = '0; fwd_mreg = '0;
   endtask

   task automatic set_wa(input int k, input logic [4:0] a);
      fwd_wa[5*k +: 5] = a;
   endtask

   initial begin
      clr();
      cpu_rst = 1;
      cyc(); cyc();
      chk_en = 1;
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_hilo_busy", hilo_busy, 0);
      cpu_rst = 0;

      // EXE and MEM both write r5: EXE wins
      rreg1 = 1; ra1 = 5; fwd_wreg = 3'b011; set_wa(0, 5); set_wa(1, 5); #1;
      chk("exe_wins_sel", fwd1_sel, 1);
      chk("exe_wins_stall", stallreq_id, 0);
      cyc(); clr();

      // Load in EXE feeding operand 2
      rreg2 = 1; ra2 = 7; fwd_wreg = 3'b001; fwd_mreg = 3'b001; set_wa(0, 7); #1;
      chk("lu_stall", stallreq_id, 1);
      chk("lu_issue", id_issue, 0);
      cyc();
      chk("lu_cnt", stall_cnt, 1);
      clr();

      // $zero never forwarded nor stalled
      rreg1 = 1; ra1 = 0; fwd_wreg = 3'b001; fwd_mreg = 3'b001; set_wa(0, 0); #1;
      chk("zero_sel", fwd1_sel, 0);
      chk("zero_stall", stallreq_id, 0);
      cyc(); clr();

      // Load already in a data-ready stage forwards without stalling
      rreg1 = 1; ra1 = 9; fwd_wreg = 3'b100; fwd_mreg = 3'b100; set_wa(2, 9); #1;
      chk("late_load_sel", fwd1_sel, 3);
      chk("late_load_stall", stallreq_id, 0);
      cyc();
      // Younger ALU write shadows older load
      fwd_wreg = 3'b011; fwd_mreg = 3'b010; set_wa(0, 9); set_wa(1, 9); #1;
      chk("shadow_sel", fwd1_sel, 1);
      chk("shadow_stall", stallreq_id, 0);
      cyc(); clr();

      // div, then mflo stalls for DC cycles
      id_div = 1; id_hilo_use = 1; #1;
      chk("div_issue", id_issue, 1);
      cyc();
      id_div = 0;
      for (int i = 0; i < DC; i++) begin
         chk("div_busy", hilo_busy, 1);
         chk("mflo_stall", stallreq_id, 1);
         cyc();
      end
      chk("div_done", hilo_busy, 0);
      chk("mflo_issue", id_issue, 1);
      cyc(); clr();

      // flush doesn't cancel a div; reset does
      id_div = 1; cyc();
      id_div = 0; flush = 1; cyc();
      chk("flush_busy", hilo_busy, 1);
      cyc();
      chk("flush_busy2", hilo_busy, 1);
      flush = 0; cpu_rst = 1; cyc();
      cpu_rst = 0;
      chk("rst_mid_div", hilo_busy, 0);
      clr();

      // Saturating stall counter
      rreg1 = 1; ra1 = 3; fwd_wreg = 3'b001; fwd_mreg = 3'b001; set_wa(0, 3);
      repeat (20) cyc();
      chk("cnt_sat", stall_cnt, CMAX);
      clr();
      cpu_rst = 1; cyc(); cpu_rst = 0;

      // Random traffic, small register space to provoke matches
      for (int i = 0; i < 3000; i++) begin
         cpu_rst     = ($urandom_range(0, 99) == 0);
         id_valid    = ($urandom_range(0, 7) != 0);
         flush       = ($urandom_range(0, 9) == 0);
         rreg1       = $urandom_range(0, 1);
         rreg2       = $urandom_range(0, 1);
         ra1         = 5'($urandom_range(0, 3));
         ra2         = 5'($urandom_range(0, 3));
         id_div      = ($urandom_range(0, 7) == 0);
         id_hilo_use = id_div | ($urandom_range(0, 3) == 0);
         fwd_wreg    = NF'($urandom);
         fwd_mreg    = NF'($urandom);
         for (int k = 0; k < NF; k++) set_wa(k, 5'($urandom_range(0, 3)));
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
